// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: EX-stage issue/retire controller for the RV64M mul/div unit.
// Define MDU_SPECIAL_FASTPATH_EN to retire div-by-zero/overflow ops at accept.
module mdu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [2:0]       in_func3,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             flush,
    output logic             mdu_en,
    output logic [XLEN-1:0]  mdu_rsA,
    output logic [XLEN-1:0]  mdu_rsB,
    output logic [2:0]       mdu_func3,
    output logic             mdu_w_en,
    input  logic             mdu_ready,
    input  logic [XLEN-1:0]  mdu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nx;
    logic   accept, capture, fast_hit;
    logic   [XLEN-1:0] cap_val;

    function automatic logic div_zero(
        input logic [XLEN-1:0] b,
        input logic            w
    );
        return w ? (b[31:0] == 32'h0) : (b == '0);
    endfunction

    function automatic logic special(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      f,
        input logic            w
    );
        logic ovf;
        ovf = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == MIN_S && b == '1);
        return (f[2] & div_zero(b, w))
             | (ovf & (f == 3'b100 || f == 3'b110));
    endfunction

    // Only meaningful for ops flagged by special(); rem selects REM/REMU.
    function automatic logic [XLEN-1:0] fixup(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic            rem,
        input logic            w
    );
        if (div_zero(b, w))
            return rem ? a : '1;
        return rem ? '0 : a;
    endfunction

    function automatic logic [XLEN-1:0] sext_w(
        input logic [XLEN-1:0] r,
        input logic            w
    );
        return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    assign accept  = in_valid & in_ready;
    assign capture = (state == ISSUE) & mdu_ready & ~flush;

`ifdef MDU_SPECIAL_FASTPATH_EN
    assign fast_hit = special(in_rs1, in_rs2, in_func3, in_word);
`else
    assign fast_hit = 1'b0;
`endif

    assign cap_val = sext_w(
        special(mdu_rsA, mdu_rsB, mdu_func3, mdu_w_en)
            ? fixup(mdu_rsA, mdu_rsB, mdu_func3[1], mdu_w_en)
            : mdu_result,
        mdu_w_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (accept)
                    state_nx = fast_hit ? DONE : ISSUE;
            ISSUE:
                if (mdu_ready)
                    state_nx = DONE;
            DONE:
                if (out_ready)
                    state_nx = accept ? (fast_hit ? DONE : ISSUE) : IDLE;
            default:
                state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    always_comb begin
        mdu_en    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = ~flush;
            end
            ISSUE:
                mdu_en = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~flush;
            end
            default:
                busy = 1'b0;
        endcase
    end

    // Operand latches double as the unit interface and the WB tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_rsA   <= '0;
            mdu_rsB   <= '0;
            mdu_func3 <= '0;
            mdu_w_en  <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            op_cnt    <= '0;
        end else begin
            if (accept) begin
                mdu_rsA   <= in_rs1;
                mdu_rsB   <= in_rs2;
                mdu_func3 <= in_func3;
                mdu_w_en  <= in_word;
                out_rd    <= in_rd;
            end
            if (capture)
                out_data <= cap_val;
            else if (accept && fast_hit)
                out_data <= sext_w(
                    fixup(in_rs1, in_rs2, in_func3[1], in_word),
                    in_word);
            if (out_valid && out_ready)
                op_cnt <= op_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: randomized bench against an ISA-level RV64M reference.
// Builds with or without MDU_SPECIAL_FASTPATH_EN.
module tb_mdu_issue_ctrl;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam int CNT_W = 16;

`ifdef MDU_SPECIAL_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [2:0]       f;
        logic             w;
        logic [TAG_W-1:0] rd;
    } op_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [2:0]       in_func3;
    logic             in_word;
    logic [TAG_W-1:0] in_rd;
    logic             flush;
    logic             mdu_en;
    logic [XLEN-1:0]  mdu_rsA;
    logic [XLEN-1:0]  mdu_rsB;
    logic [2:0]       mdu_func3;
    logic             mdu_w_en;
    logic             mdu_ready;
    logic [XLEN-1:0]  mdu_result;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_rd;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    int               n_chk;
    int               n_err;
    int               unit_lat;
    bit               stray;
    logic [CNT_W-1:0] cnt_ref;

    mdu_issue_ctrl #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_func3   (in_func3),
        .in_word    (in_word),
        .in_rd      (in_rd),
        .flush      (flush),
        .mdu_en     (mdu_en),
        .mdu_rsA    (mdu_rsA),
        .mdu_rsB    (mdu_rsB),
        .mdu_func3  (mdu_func3),
        .mdu_w_en   (mdu_w_en),
        .mdu_ready  (mdu_ready),
        .mdu_result (mdu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .busy       (busy),
        .op_cnt     (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_sp(input op_t o);
        bit z, ov;
        z  = o.w ? (o.b[31:0] == 32'h0) : (o.b == 64'h0);
        ov = o.w ? (o.a[31:0] == 32'h8000_0000 && o.b[31:0] == 32'hFFFF_FFFF)
                 : (o.a == 64'h8000_0000_0000_0000 && o.b == '1);
        return (o.f >= 3'd4) && (z || (ov && (o.f == 3'd4 || o.f == 3'd6)));
    endfunction

    // Architectural RV64M result, including divide-by-zero/overflow rules.
    function automatic logic [63:0] ref_m(input op_t o);
        logic [127:0]      sa, sb, za, zb, p;
        logic signed [63:0] a, b, q64, m64;
        logic signed [31:0] a32, b32, q32, m32;
        logic [31:0]        r32;
        logic [63:0]        r;
        bit                 ov64, ov32;
        a   = o.a;
        b   = o.b;
        a32 = o.a[31:0];
        b32 = o.b[31:0];
        sa  = {{64{o.a[63]}}, o.a};
        sb  = {{64{o.b[63]}}, o.b};
        za  = {64'h0, o.a};
        zb  = {64'h0, o.b};
        ov64 = o.a == 64'h8000_0000_0000_0000 && o.b == '1;
        ov32 = o.a[31:0] == 32'h8000_0000 && o.b[31:0] == 32'hFFFF_FFFF;
        q64 = '0; m64 = '0; q32 = '0; m32 = '0;
        if (o.b != 64'h0 && !ov64) begin
            q64 = a / b;
            m64 = a % b;
        end
        if (o.b[31:0] != 32'h0 && !ov32) begin
            q32 = a32 / b32;
            m32 = a32 % b32;
        end
        r = '0;
        r32 = '0;
        if (o.w) begin
            case (o.f)
                3'd0: r32 = o.a[31:0] * o.b[31:0];
                3'd4: r32 = (o.b[31:0] == 0) ? 32'hFFFF_FFFF
                          : ov32 ? o.a[31:0] : q32;
                3'd5: r32 = (o.b[31:0] == 0) ? 32'hFFFF_FFFF
                          : o.a[31:0] / o.b[31:0];
                3'd6: r32 = (o.b[31:0] == 0) ? o.a[31:0]
                          : ov32 ? 32'h0 : m32;
                3'd7: r32 = (o.b[31:0] == 0) ? o.a[31:0]
                          : o.a[31:0] % o.b[31:0];
                default: r32 = 32'h0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o.f)
                3'd0: r = o.a * o.b;
                3'd1: begin p = sa * sb; r = p[127:64]; end
                3'd2: begin p = sa * zb; r = p[127:64]; end
                3'd3: begin p = za * zb; r = p[127:64]; end
                3'd4: r = (o.b == 0) ? '1 : ov64 ? o.a : q64;
                3'd5: r = (o.b == 0) ? '1 : o.a / o.b;
                3'd6: r = (o.b == 0) ? o.a : ov64 ? 64'h0 : m64;
                default: r = (o.b == 0) ? o.a : o.a % o.b;
            endcase
        end
        return r;
    endfunction

    // Stand-in unit: junk for special cases and for the upper half of W ops.
    function automatic logic [63:0] unit_resp(input op_t o);
        logic [63:0] r;
        if (is_sp(o))
            return {$urandom, $urandom};
        r = ref_m(o);
        if (o.w)
            r[63:32] = $urandom;
        return r;
    endfunction

    initial begin
        int  cnt;
        op_t u;
        cnt = 0;
        mdu_ready  = 1'b0;
        mdu_result = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mdu_en) begin
                if (cnt == unit_lat) begin
                    u.a = mdu_rsA; u.b = mdu_rsB; u.f = mdu_func3;
                    u.w = mdu_w_en; u.rd = '0;
                    mdu_ready  = 1'b1;
                    mdu_result = unit_resp(u);
                end else begin
                    mdu_ready = 1'b0;
                end
                cnt++;
            end else begin
                cnt        = 0;
                mdu_ready  = stray;
                mdu_result = {$urandom, $urandom};
            end
        end
    end

    function automatic logic [63:0] pick(input bit w, input bit dvd);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: if (dvd)
                   r = w ? {r[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
               else
                   r = w ? {r[63:32], 32'h0} : 64'h0;
            1: r = w ? {r[63:32], 32'hFFFF_FFFF} : '1;
            2: r = 64'($urandom_range(0, 100));
            default: ;
        endcase
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.w = ($urandom_range(0, 2) == 0);
        o.f = 3'($urandom_range(0, 7));
        if (o.w && o.f inside {[3'd1:3'd3]})
            o.f = o.f + 3'd3;
        o.a  = pick(o.w, 1'b1);
        o.b  = pick(o.w, 1'b0);
        o.rd = TAG_W'($urandom);
        return o;
    endfunction

    function automatic op_t mk(input logic [63:0] a, input logic [63:0] b,
                               input logic [2:0] f, input logic w,
                               input logic [TAG_W-1:0] rd);
        op_t o;
        o.a = a; o.b = b; o.f = f; o.w = w; o.rd = rd;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        in_rs1   = o.a;
        in_rs2   = o.b;
        in_func3 = o.f;
        in_word  = o.w;
        in_rd    = o.rd;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_wait", 64'(n < 20), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input op_t o, input int lat);
        int c, en_n, exp_en;
        exp_en = (FAST && is_sp(o)) ? 0 : lat + 1;
        c = 1;
        en_n = 0;
        while (!out_valid && c <= 30) begin
            check("busy_run", 64'(busy), 64'd1);
            if (mdu_en) begin
                en_n++;
                check("mdu_rsA", mdu_rsA, o.a);
                check("mdu_rsB", mdu_rsB, o.b);
                check("mdu_func3", 64'(mdu_func3), 64'(o.f));
                check("mdu_w_en", 64'(mdu_w_en), 64'(o.w));
            end
            @(negedge clk);
            c++;
        end
        check("out_valid_lat", 64'(c), 64'(exp_en + 1));
        check("mdu_en_cycles", 64'(en_n), 64'(exp_en));
        check("out_data", out_data, ref_m(o));
        check("out_rd", 64'(out_rd), 64'(o.rd));
    endtask

    task automatic hold(input op_t o, input int h);
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, ref_m(o));
            check("hold_rd", 64'(out_rd), 64'(o.rd));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        #1;
        check("in_ready_done", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        cnt_ref++;
        check("post_valid", 64'(out_valid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("op_cnt", 64'(op_cnt), 64'(cnt_ref));
    endtask

    task automatic retire_b2b(input op_t nxt);
        drive_op(nxt);
        out_ready = 1'b1;
        #1;
        check("in_ready_b2b", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_ref++;
        check("op_cnt_b2b", 64'(op_cnt), 64'(cnt_ref));
        check("busy_b2b", 64'(busy), 64'd1);
    endtask

    task automatic run_op(input op_t o, input int lat, input int h);
        unit_lat = lat;
        drive_op(o);
        wait_accept();
        collect(o, lat);
        hold(o, h);
        retire();
    endtask

    initial begin
        op_t cur, nxt, o;
        int  lat, nlat;
        bit  pending;
        n_chk = 0; n_err = 0; cnt_ref = '0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_func3 = '0; in_word = 1'b0;
        in_rd = '0; stray = 1'b0; unit_lat = 0;
        repeat (3) @(negedge clk);
        check("rst_mdu_en", 64'(mdu_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_cnt", 64'(op_cnt), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_rsA", mdu_rsA, 64'd0);
        check("rst_rsB", mdu_rsB, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(mk(64'd3, 64'd5, 3'd0, 1'b0, 5'd7), 0, 2);
        run_op(mk(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd4, 1'b1, 5'd9), 1, 0);
        run_op(mk(64'h8000_0000_0000_0000, '1, 3'd4, 1'b0, 5'd3), 2, 1);

        // REMU by zero, 5-cycle WB stall, then back-to-back issue.
        cur = mk(64'd42, 64'd0, 3'd7, 1'b0, 5'd12);
        unit_lat = 0;
        drive_op(cur);
        wait_accept();
        collect(cur, 0);
        hold(cur, 5);
        nxt = mk(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210,
                 3'd3, 1'b0, 5'd30);
        unit_lat = 1;
        retire_b2b(nxt);
        collect(nxt, 1);
        retire();

        // Flush in ISSUE; a late ready pulse must be ignored.
        unit_lat = 3;
        o = mk(64'd6, 64'd7, 3'd0, 1'b0, 5'd4);
        drive_op(o);
        wait_accept();
        check("flush_pre_en", 64'(mdu_en), 64'd1);
        flush = 1'b1;
        drive_op(mk(64'd1, 64'd1, 3'd0, 1'b0, 5'd1));
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        stray = 1'b1;
        check("flush_en", 64'(mdu_en), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("flush_valid", 64'(out_valid), 64'd0);
            check("flush_idle", 64'(busy), 64'd0);
        end
        stray = 1'b0;
        @(negedge clk);
        run_op(mk(64'd100, 64'd7, 3'd6, 1'b0, 5'd21), 1, 1);

        // Flush while holding a result in DONE.
        o = mk(64'd9, 64'd0, 3'd5, 1'b1, 5'd17);
        unit_lat = 0;
        drive_op(o);
        wait_accept();
        collect(o, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_valid", 64'(out_valid), 64'd0);
        check("flush_done_busy", 64'(busy), 64'd0);
        check("flush_done_cnt", 64'(op_cnt), 64'(cnt_ref));

        pending = 1'b0;
        lat = $urandom_range(0, 3);
        cur = rand_op();
        for (int i = 0; i < 60; i++) begin
            unit_lat = lat;
            if (!pending) begin
                drive_op(cur);
                wait_accept();
            end
            collect(cur, lat);
            stray = 1'($urandom_range(0, 1));
            hold(cur, $urandom_range(0, 3));
            stray = 1'b0;
            nlat = $urandom_range(0, 3);
            nxt = rand_op();
            if ($urandom_range(0, 1) == 1) begin
                unit_lat = nlat;
                retire_b2b(nxt);
                pending = 1'b1;
            end else begin
                retire();
                pending = 1'b0;
            end
            cur = nxt;
            lat = nlat;
        end
        if (pending) begin
            collect(cur, lat);
            retire();
        end

        // Asynchronous reset in the middle of ISSUE.
        unit_lat = 3;
        o = mk(64'd11, 64'd13, 3'd0, 1'b0, 5'd5);
        drive_op(o);
        wait_accept();
        check("arst_pre_en", 64'(mdu_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_en", 64'(mdu_en), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_cnt", 64'(op_cnt), 64'd0);
        check("arst_data", out_data, 64'd0);
        cnt_ref = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(mk(64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF,
                  3'd6, 1'b1, 5'd8), 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
